// File: rtl/memcpy_arbiter.sv
// Round-robin arbiter that shares one memcpy engine between NREQ requesters.
// One descriptor is in flight at a time; zero-size copies complete without starting the engine.
module memcpy_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 64,
    parameter int SIZE_W = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_src,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_dst,
    input  logic [NREQ-1:0][SIZE_W-1:0] req_size,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             cpl_valid,
    output logic                        mc_en,
    output logic [ADDR_W-1:0]           mc_src,
    output logic [ADDR_W-1:0]           mc_dst,
    output logic [SIZE_W-1:0]           mc_size,
    input  logic                        mc_done,
    output logic                        busy
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, CPL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic             accept;
    int               idx;

    // Scan from the lowest offset last so the first valid requester at or above rr_ptr wins.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

    assign accept = (state == IDLE) && (|grant);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (req_size[grant_idx] == '0) ? CPL : LAUNCH;
            LAUNCH:  state_nxt = BUSY;
            BUSY:    if (mc_done) state_nxt = CPL;
            CPL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        cpl_valid = '0;
        mc_en     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    req_ready = grant;
            LAUNCH:  mc_en = 1'b1;
            CPL:     cpl_valid[owner] = 1'b1;
            default: ;
        endcase
    end

    // Descriptor is held from accept until the next accept; the served requester drops to lowest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            owner   <= '0;
            mc_src  <= '0;
            mc_dst  <= '0;
            mc_size <= '0;
        end else if (accept) begin
            mc_src  <= req_src[grant_idx];
            mc_dst  <= req_dst[grant_idx];
            mc_size <= req_size[grant_idx];
            owner   <= grant_idx;
            rr_ptr  <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_memcpy_arbiter.sv
// Self-checking bench for memcpy_arbiter: expected grant order is queued by the stimulus,
// descriptors and completions are scoreboarded as the DUT accepts, launches and completes.
module tb_memcpy_arbiter;
    localparam int NREQ   = 4;
    localparam int ADDR_W = 64;
    localparam int SIZE_W = 15;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NREQ-1:0]             req_valid = '0;
    logic [NREQ-1:0][ADDR_W-1:0] req_src = '0;
    logic [NREQ-1:0][ADDR_W-1:0] req_dst = '0;
    logic [NREQ-1:0][SIZE_W-1:0] req_size = '0;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             cpl_valid;
    logic                        mc_en;
    logic [ADDR_W-1:0]           mc_src;
    logic [ADDR_W-1:0]           mc_dst;
    logic [SIZE_W-1:0]           mc_size;
    logic                        mc_done = 1'b0;
    logic                        busy;

    memcpy_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst), .req_size(req_size),
        .req_ready(req_ready), .cpl_valid(cpl_valid),
        .mc_en(mc_en), .mc_src(mc_src), .mc_dst(mc_dst), .mc_size(mc_size),
        .mc_done(mc_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [SIZE_W-1:0] size;
    } launch_t;

    typedef struct {
        int owner;
        bit zero;
    } cpl_t;

    int      exp_grant[$];
    launch_t exp_launch[$];
    cpl_t    exp_cpl[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int grant_cnt = 0, cpl_cnt = 0, en_cnt = 0;
    int acc_cyc = 0, cpl_cyc = 0, done_cyc = 0;
    bit eng_enable = 1'b1;
    int eng_delay = 5, eng_len = 1;

    int      mg;
    launch_t ml;
    cpl_t    mcp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (|req_ready) begin
                check("ready_within_valid", 64'(req_ready & ~req_valid), 64'd0);
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 64'(req_ready), 64'd0);
                end else begin
                    mg = exp_grant.pop_front();
                    check("grant", 64'(req_ready), 64'd1 << mg);
                    acc_cyc = cyc;
                    grant_cnt++;
                    mcp.owner = mg;
                    mcp.zero  = (req_size[mg] == '0);
                    exp_cpl.push_back(mcp);
                    if (req_size[mg] != '0) begin
                        ml.src  = req_src[mg];
                        ml.dst  = req_dst[mg];
                        ml.size = req_size[mg];
                        exp_launch.push_back(ml);
                    end
                end
            end
            if (mc_en) begin
                en_cnt++;
                if (exp_launch.size() == 0) begin
                    check("unexpected_mc_en", 64'(mc_en), 64'd0);
                end else begin
                    ml = exp_launch.pop_front();
                    check("mc_src", mc_src, ml.src);
                    check("mc_dst", mc_dst, ml.dst);
                    check("mc_size", 64'(mc_size), 64'(ml.size));
                    check("en_latency", 64'(cyc), 64'(acc_cyc + 1));
                end
            end
            if (|cpl_valid) begin
                cpl_cnt++;
                if (exp_cpl.size() == 0) begin
                    check("unexpected_cpl", 64'(cpl_valid), 64'd0);
                end else begin
                    mcp = exp_cpl.pop_front();
                    check("cpl_owner", 64'(cpl_valid), 64'd1 << mcp.owner);
                    check("cpl_latency", 64'(cyc), mcp.zero ? 64'(acc_cyc + 1) : 64'(done_cyc + 1));
                    cpl_cyc = cyc;
                end
            end
        end
    end

    // Engine model: raises done eng_delay cycles after mc_en and holds it eng_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (mc_en && eng_enable && !reset) begin
                repeat (eng_delay) @(posedge clk);
                #1;
                mc_done  = 1'b1;
                done_cyc = cyc;
                repeat (eng_len) @(posedge clk);
                #1;
                mc_done = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grants(input int target);
        int t = 0;
        while (grant_cnt < target && t < 2000) begin
            tick();
            t++;
        end
        if (grant_cnt < target) check("grant_timeout", 64'(grant_cnt), 64'(target));
    endtask

    task automatic wait_cpls(input int target);
        int t = 0;
        while (cpl_cnt < target && t < 2000) begin
            tick();
            t++;
        end
        if (cpl_cnt < target) check("cpl_timeout", 64'(cpl_cnt), 64'(target));
    endtask

    task automatic post(input int i, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [SIZE_W-1:0] n);
        req_src[i]   = s;
        req_dst[i]   = d;
        req_size[i]  = n;
        req_valid[i] = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_cpl_valid"}, 64'(cpl_valid), 64'd0);
        check({tag, "_mc_en"}, 64'(mc_en), 64'd0);
        check({tag, "_mc_src"}, mc_src, 64'd0);
        check({tag, "_mc_dst"}, mc_dst, 64'd0);
        check({tag, "_mc_size"}, 64'(mc_size), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int p, base, cb, eb;

        // Reset state
        tick(2);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // 1: single copy, done at cycle 40 -> completion at 41
        eng_delay = 39;
        exp_grant.push_back(0);
        post(0, 64'h1000, 64'h2000, 15'd16);
        p = cyc;
        wait_grants(1);
        check("t1_accept_cycle", 64'(acc_cyc), 64'(p));
        req_valid = '0;
        wait_cpls(1);
        check("t1_done_cycle", 64'(done_cyc - acc_cyc), 64'd40);
        check("t1_cpl_cycle", 64'(cpl_cyc - acc_cyc), 64'd41);
        eng_delay = 5;

        // Restart arbitration from requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // 2: all four requesting continuously -> strict rotation 0,1,2,3,0
        base = grant_cnt;
        eb   = en_cnt;
        for (int i = 0; i < NREQ; i++) begin
            post(i, 64'h1_0000 * (i + 1) + 64'h40, 64'h8000_0000 + 64'h100 * i, SIZE_W'(8 + 4 * i));
        end
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        wait_grants(base + 5);
        // 3: only requesters 1 and 3 -> 1 then 3, then 0 alone at its first idle
        exp_grant.push_back(1);
        exp_grant.push_back(3);
        exp_grant.push_back(0);
        req_valid = 4'b1010;
        wait_grants(base + 6);
        req_valid = 4'b1000;
        wait_grants(base + 7);
        post(0, 64'hDEAD_0000, 64'hBEEF_0000, 15'd100);
        req_valid = 4'b0001;
        wait_grants(base + 8);
        check("t3_req0_first_idle", 64'(acc_cyc), 64'(cpl_cyc + 1));
        req_valid = '0;
        wait_cpls(cpl_cnt + 1);
        check("t2_t3_en_count", 64'(en_cnt - eb), 64'd8);

        // 4: zero-size copy completes without engine start
        tick(2);
        eb = en_cnt;
        exp_grant.push_back(2);
        post(2, 64'h3000, 64'h4000, 15'd0);
        check("t4_busy_c0", 64'(busy), 64'd0);
        tick();
        req_valid = '0;
        check("t4_busy_c1", 64'(busy), 64'd1);
        check("t4_cpl_c1", 64'(cpl_valid), 64'b0100);
        tick();
        check("t4_busy_c2", 64'(busy), 64'd0);
        tick(5);
        check("t4_no_mc_en", 64'(en_cnt - eb), 64'd0);

        // 5: reset during BUSY drops the copy; later arbitration behaves normally
        eng_enable = 1'b0;
        exp_grant.push_back(1);
        post(1, 64'h5000, 64'h6000, 15'd8);
        wait_grants(grant_cnt + 1);
        req_valid = '0;
        tick(3);
        check("t5_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("t5_after_reset");
        exp_cpl.delete();
        cb = cpl_cnt;
        tick(10);
        check("t5_no_cpl", 64'(cpl_cnt), 64'(cb));
        eng_enable = 1'b1;
        exp_grant.push_back(3);
        post(3, 64'h7000, 64'h7800, 15'd64);
        wait_grants(grant_cnt + 1);
        req_valid = '0;
        wait_cpls(cb + 1);
        exp_grant.push_back(0);
        exp_grant.push_back(3);
        post(0, 64'hA000, 64'hB000, 15'd12);
        post(3, 64'hC000, 64'hD000, 15'd20);
        base = grant_cnt;
        wait_grants(base + 1);
        req_valid[0] = 1'b0;
        wait_grants(base + 2);
        req_valid = '0;
        wait_cpls(cb + 3);

        // 6: done ignored in IDLE; held done gives one completion; request during BUSY waits
        tick(2);
        cb = cpl_cnt;
        mc_done = 1'b1;
        tick();
        mc_done = 1'b0;
        tick(3);
        check("t6_idle_done_ignored", 64'(cpl_cnt), 64'(cb));
        eng_len = 3;
        exp_grant.push_back(2);
        exp_grant.push_back(1);
        post(2, 64'h1_2345_6780, 64'h9_8765_4320, 15'h7FFF);
        base = grant_cnt;
        wait_grants(base + 1);
        req_valid[2] = 1'b0;
        tick();
        post(1, 64'hE000, 64'hF000, 15'd4);
        wait_grants(base + 2);
        check("t6_req1_after_cpl", 64'(acc_cyc), 64'(cpl_cyc + 1));
        check("t6_single_cpl", 64'(cpl_cnt - cb), 64'd1);
        req_valid = '0;
        wait_cpls(cb + 2);
        eng_len = 1;

        tick(5);
        check("grant_queue_empty", 64'(exp_grant.size()), 64'd0);
        check("launch_queue_empty", 64'(exp_launch.size()), 64'd0);
        check("cpl_queue_empty", 64'(exp_cpl.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
